// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer: a constant log2,
// a bit-reversal helper and the read-side state type.
package fft_pkg;

    // Read side state: idle, or streaming one bank out in natural order
    typedef enum logic {
        IDLE = 1'b0,
        READ = 1'b1
    } rd_state_t;

    // Ceiling log2, used to size counters from the frame length
    function automatic int log2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Reverse the low 'bits' bits of value; upper result bits are zero
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int bits);
        logic [31:0] r;
        logic [31:0] v;
        r = '0;
        v = value;
        for (int b = 0; b < 32; b++) begin
            if (b < bits) begin
                r = {r[30:0], v[0]};
                v = v >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_if.sv
// Stream interface of the reorder buffer: bit-reversed input stream and
// natural-order output stream, both using enable/real/imag signalling.
// frame_err exists only when FFT_REORDER_ERR_EN is defined.
interface fft_reorder_if #(
    parameter int WIDTH = 16
);
    logic             idata_en;
    logic [WIDTH-1:0] idata_r;
    logic [WIDTH-1:0] idata_i;
    logic             odata_en;
    logic [WIDTH-1:0] odata_r;
    logic [WIDTH-1:0] odata_i;
`ifdef FFT_REORDER_ERR_EN
    logic             frame_err;
`endif

`ifdef FFT_REORDER_ERR_EN
    // Upstream side: produces the input stream, observes the output stream
    modport master (
        output idata_en, idata_r, idata_i,
        input  odata_en, odata_r, odata_i, frame_err
    );

    // Reorder buffer side
    modport slave (
        input  idata_en, idata_r, idata_i,
        output odata_en, odata_r, odata_i, frame_err
    );
`else
    // Upstream side: produces the input stream, observes the output stream
    modport master (
        output idata_en, idata_r, idata_i,
        input  odata_en, odata_r, odata_i
    );

    // Reorder buffer side
    modport slave (
        input  idata_en, idata_r, idata_i,
        output odata_en, odata_r, odata_i
    );
`endif

endinterface

// File: rtl/reorder_ram.sv
// Simple dual-port RAM holding both ping-pong banks, addressed {bank, index}.
// Synchronous write, synchronous read. The array itself is never reset; the
// read data register is, because it drives the block outputs directly.
module reorder_ram #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] r_rdata;

    // Write port: store one sample per enabled cycle
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered read, cleared on reset so outputs read zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_reorder.sv
// Output reorder buffer for the radix-2^2 SDF FFT pipeline.
// Accepts one N-point frame in bit-reversed order and replays it in natural
// order. Two N-entry banks alternate so one frame is written while the
// previous one is read, allowing back-to-back frames at full rate.
// Optional feature: define FFT_REORDER_ERR_EN to add the frame_err pulse,
// raised the cycle after a partially written frame is abandoned.
module fft_reorder
    import fft_pkg::*;
#(
    parameter int N     = 64,
    parameter int WIDTH = 16
) (
    input  logic          clock,
    input  logic          reset,
    fft_reorder_if.slave  bus
);

    localparam int LOG_N = log2(N);
    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    // Write side state
    logic [LOG_N-1:0] r_wcnt;
    logic             r_wsel;

    // Read side state
    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic [LOG_N-1:0] r_rcnt;
    logic [LOG_N-1:0] w_rcnt_nxt;
    logic             r_rsel;
    logic             w_rsel_nxt;

    // Output enable travels one cycle behind the read issue, alongside the
    // registered RAM data
    logic             r_odata_en;

    logic             w_rd_start;
    logic             w_re;
    logic [LOG_N:0]   w_waddr;
    logic [LOG_N:0]   w_raddr;
    logic [LOG_N-1:0] w_wcnt_rev;
    logic [2*WIDTH-1:0] w_wdata;
    logic [2*WIDTH-1:0] w_rdata;

    // The last sample of a frame is being written this cycle, so the bank is
    // complete at the next edge and reading can begin in the following cycle
    assign w_rd_start = bus.idata_en && (r_wcnt == LAST);

    assign w_wcnt_rev = LOG_N'(bitrev(32'(r_wcnt), LOG_N));
    assign w_waddr    = {r_wsel, w_wcnt_rev};
    assign w_wdata    = {bus.idata_r, bus.idata_i};

    assign w_re       = (r_state == READ);
    assign w_raddr    = {r_rsel, r_rcnt};

    // Write counter and bank select; a dropped enable mid-frame discards the
    // partial frame by rewinding to address 0 of the same bank
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wcnt <= '0;
            r_wsel <= 1'b0;
        end else if (bus.idata_en) begin
            if (r_wcnt == LAST) begin
                r_wcnt <= '0;
                r_wsel <= ~r_wsel;
            end else begin
                r_wcnt <= r_wcnt + 1'b1;
            end
        end else begin
            r_wcnt <= '0;
        end
    end

    // Read FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_rcnt  <= '0;
            r_rsel  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rcnt  <= w_rcnt_nxt;
            r_rsel  <= w_rsel_nxt;
        end
    end

    // Read FSM next state: start on a completed bank, walk addresses in
    // natural order, and chain straight into the next bank if it completes
    // exactly as the current one finishes
    always_comb begin
        w_state_nxt = r_state;
        w_rcnt_nxt  = r_rcnt;
        w_rsel_nxt  = r_rsel;
        case (r_state)
            IDLE: begin
                if (w_rd_start) begin
                    w_state_nxt = READ;
                    w_rcnt_nxt  = '0;
                    w_rsel_nxt  = r_wsel;
                end
            end
            READ: begin
                if (r_rcnt == LAST) begin
                    w_rcnt_nxt = '0;
                    if (w_rd_start) begin
                        w_state_nxt = READ;
                        w_rsel_nxt  = ~r_rsel;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_rcnt_nxt  = '0;
            end
        endcase
    end

    // Output enable register, aligned with the RAM read data register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_odata_en <= 1'b0;
        end else begin
            r_odata_en <= w_re;
        end
    end

    reorder_ram #(
        .ADDR_W (LOG_N + 1),
        .DATA_W (2 * WIDTH)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .i_we    (bus.idata_en),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_re),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.odata_en = r_odata_en;
    assign bus.odata_r  = w_rdata[2*WIDTH-1:WIDTH];
    assign bus.odata_i  = w_rdata[WIDTH-1:0];

`ifdef FFT_REORDER_ERR_EN
    logic w_abort;
    logic r_frame_err;

    assign w_abort = !bus.idata_en && (r_wcnt != '0);

    // One-cycle pulse following an abandoned partial frame
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_abort;
        end
    end

    assign bus.frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder: an N=16 instance for directed scenarios and an N=64
// instance for random frames, each followed by a frame-level reference model.
module tb_fft_reorder;

    localparam int W = 16;

    typedef struct {
        int          cyc;
        logic [W-1:0] r;
        logic [W-1:0] i;
    } item_t;

    logic clk;
    logic rst_n;

    logic         drv_en [2];
    logic [W-1:0] drv_r  [2];
    logic [W-1:0] drv_i  [2];
    int           pend   [2];

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Bit reversal by plain arithmetic
    function automatic int rev(input int v, input int bits);
        int r;
        r = 0;
        for (int b = 0; b < bits; b++) begin
            r = (r << 1) | ((v >> b) & 1);
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int NN = (g == 0) ? 16 : 64;
        localparam int LG = (g == 0) ? 4 : 6;

        fft_reorder_if #(.WIDTH(W)) bus ();

        assign bus.idata_en = drv_en[g];
        assign bus.idata_r  = drv_r[g];
        assign bus.idata_i  = drv_i[g];

        fft_reorder #(.N(NN), .WIDTH(W)) dut (
            .clock (clk),
            .reset (rst_n),
            .bus   (bus)
        );

        item_t        sched[$];
        logic [2*W-1:0] part[$];
        int           cyc = 0;
        int           err_cyc = -1;

        // Reference model: collect a full frame, then schedule its natural
        // order replay starting two cycles after the last sample
        always @(negedge clk) begin
            cyc++;
            if (!rst_n) begin
                part.delete();
                sched.delete();
                err_cyc = -1;
                check($sformatf("rst_en[%0d]", g), 32'(bus.odata_en), 32'd0);
                check($sformatf("rst_r[%0d]", g), 32'(bus.odata_r), 32'd0);
                check($sformatf("rst_i[%0d]", g), 32'(bus.odata_i), 32'd0);
`ifdef FFT_REORDER_ERR_EN
                check($sformatf("rst_err[%0d]", g), 32'(bus.frame_err), 32'd0);
`endif
            end else begin
                if (sched.size() > 0 && sched[0].cyc == cyc) begin
                    check($sformatf("en[%0d]@%0d", g, cyc), 32'(bus.odata_en), 32'd1);
                    check($sformatf("re[%0d]@%0d", g, cyc), 32'(bus.odata_r), 32'(sched[0].r));
                    check($sformatf("im[%0d]@%0d", g, cyc), 32'(bus.odata_i), 32'(sched[0].i));
                    void'(sched.pop_front());
                end else begin
                    check($sformatf("idle_en[%0d]@%0d", g, cyc), 32'(bus.odata_en), 32'd0);
                end
`ifdef FFT_REORDER_ERR_EN
                check($sformatf("ferr[%0d]@%0d", g, cyc), 32'(bus.frame_err),
                      32'(cyc == err_cyc));
`endif
                if (drv_en[g]) begin
                    part.push_back({drv_r[g], drv_i[g]});
                    if (part.size() == NN) begin
                        for (int k = 0; k < NN; k++) begin
                            item_t it;
                            it.cyc = cyc + 2 + k;
                            it.r   = part[rev(k, LG)][2*W-1:W];
                            it.i   = part[rev(k, LG)][W-1:0];
                            sched.push_back(it);
                        end
                        part.delete();
                    end
                end else begin
                    if (part.size() != 0) err_cyc = cyc + 1;
                    part.delete();
                end
            end
            pend[g] = sched.size();
        end
    end

    task automatic step(input int d, input logic en, input logic [W-1:0] r, input logic [W-1:0] i);
        drv_en[d] = en;
        drv_r[d]  = r;
        drv_i[d]  = i;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        for (int c = 0; c < n; c++) step(d, 1'b0, '0, '0);
    endtask

    // mode 0: r = bitrev(k)+base, i = k+base; mode 1: random data
    task automatic send_frame(input int d, input int nn, input int lg, input int mode, input int base);
        for (int k = 0; k < nn; k++) begin
            if (mode == 0) step(d, 1'b1, W'(rev(k, lg) + base), W'(k + base));
            else           step(d, 1'b1, W'($urandom), W'($urandom));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int d = 0; d < 2; d++) begin
            drv_en[d] = 1'b0;
            drv_r[d]  = '0;
            drv_i[d]  = '0;
            pend[d]   = 0;
        end
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 3);

        // Single frame
        send_frame(0, 16, 4, 0, 0);
        idle(0, 20);

        // Two back-to-back frames, second offset by 100
        send_frame(0, 16, 4, 0, 0);
        send_frame(0, 16, 4, 0, 100);
        idle(0, 20);

        // Aborted frame followed by a full one
        for (int k = 0; k < 5; k++) step(0, 1'b1, W'(500 + k), W'(600 + k));
        idle(0, 2);
        send_frame(0, 16, 4, 0, 0);
        idle(0, 20);

        // Idle gap of 7 cycles between frames
        send_frame(0, 16, 4, 0, 0);
        idle(0, 7);
        send_frame(0, 16, 4, 0, 40);
        idle(0, 20);

        // Reset during output sample 6
        send_frame(0, 16, 4, 0, 0);
        idle(0, 7);
        rst_n = 1'b0;
        #1;
        check("rst_now_en", 32'(g_dut[0].bus.odata_en), 32'd0);
        check("rst_now_r", 32'(g_dut[0].bus.odata_r), 32'd0);
        check("rst_now_i", 32'(g_dut[0].bus.odata_i), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(0, 20);
        send_frame(0, 16, 4, 0, 7);
        idle(0, 20);

        // Random frames on N=16 with a random gap, plus a random abort
        send_frame(0, 16, 4, 1, 0);
        idle(0, $urandom_range(0, 3));
        send_frame(0, 16, 4, 1, 0);
        for (int k = 0; k < 9; k++) step(0, 1'b1, W'($urandom), W'($urandom));
        idle(0, 1);
        send_frame(0, 16, 4, 1, 0);
        idle(0, 20);

        // N=64: four consecutive random frames
        for (int f = 0; f < 4; f++) send_frame(1, 64, 6, 1, 0);
        idle(1, 10);

        // Drain with a bounded wait
        for (int c = 0; c < 200 && (pend[0] != 0 || pend[1] != 0); c++) idle(1, 1);
        check("drain0", 32'(pend[0]), 32'd0);
        check("drain1", 32'(pend[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
